hitmap_lcmap_sched: RTL and testbench
=====================================

Name: hitmap_lcmap_sched

Overview:
- Schedules a shared 5-bit hitmap/lcmap two-stage shift datapath between NREQ requesters (layer-combiner / road units).
- Arbitrates round-robin and drives the datapath ce, input muxes and reset.
- Enforces the datapath's minimum ce spacing: its first stage is overwritten by any ce within 4 cycles.
- Tracks in-flight items and returns each result tagged with its requester id.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; equals clog2(NREQ).
- MIN_GAP, 4, minimum cycles between consecutive dp_ce pulses.
- DP_LAT, 5, cycles from dp_ce high until datapath outputs hold that item.

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- req  in  NREQ  per-requester request level, held until granted
- req_hitmap  in  NREQ*5  per-requester hitmap; slice i = bits [5i+4:5i]
- req_lcmap  in  NREQ*5  per-requester lcmap, same slicing
- hold  in  1  downstream stall; blocks new issue only
- grant  out  NREQ  one-hot, 1-cycle pulse, coincident with dp_ce
- dp_ce  out  1  datapath clock enable
- dp_reset  out  1  datapath reset, active-high
- dp_hitmap  out  5  datapath hitmap input
- dp_lcmap  out  5  datapath lcmap input
- dp_hitmap_out  in  5  datapath hitmap output
- dp_lcmap_out  in  5  datapath lcmap output
- res_valid  out  1  1-cycle result strobe
- res_id  out  ID_W  requester id of the result
- res_hitmap  out  5  result hitmap
- res_lcmap  out  5  result lcmap
- busy  out  1  high while any item is in flight or the gap counter is nonzero

Behaviour:
- Reset (reset=0 sampled at an edge):
  - All registered outputs go to 0; dp_reset=1; round-robin pointer goes to 0.
  - Gap counter and in-flight pipeline are cleared; in-flight results are discarded, never emitted.
  - dp_reset deasserts on the first edge with reset=1.
- All outputs except busy are registered. busy is combinational from internal state.
- FSM states:
  - IDLE -> ISSUE when (|req) & !hold & gap==0 & !reset_active.
  - ISSUE lasts exactly 1 cycle:
    - grant[k]=1, dp_ce=1, dp_hitmap/dp_lcmap = slice k.
    - Gap counter loads MIN_GAP-1; next state is GAP.
  - GAP: counter decrements each cycle; at 0 -> IDLE.
  - With default parameters, back-to-back issue cycles are c, c+4, c+8… Maximum throughput is 1 item per MIN_GAP cycles.
- Arbitration:
  - k is the first requester with req=1 at or after the pointer, searching modulo NREQ.
  - After the grant the pointer becomes (k+1) mod NREQ; it does not change when no grant is made.
  - A requester sees grant in cycle c and must deassert or update req/data by cycle c+1. Req is not resampled before c+MIN_GAP.
- Result path:
  - A valid/id shift register of depth DP_LAT+1 is loaded at issue.
  - For an item issued in cycle c, the datapath outputs are valid in cycle c+5.
  - The controller registers them, so res_valid=1 in cycle c+6, with res_id=k and res_hitmap/res_lcmap = dp outputs sampled in c+5.
  - Results are in issue order; at most ceil((DP_LAT+1)/MIN_GAP) items are in flight.
- hold:
  - Prevents the IDLE->ISSUE transition only. In-flight results still emerge; there is no result backpressure.
  - Hold rising during GAP has no effect until IDLE.
- Simultaneous events:
  - req rising in the same cycle gap reaches 0 is eligible that cycle.
  - Reset during ISSUE suppresses res_valid for that item.
- Data with no req is ignored. A requester dropping req before grant is simply not served.

Decomposition:
- Package gf_hitmap_pkg: HIT_W=5, DP_LAT=5, MIN_GAP=4, and function clog2.
- Sub-module gf_rr_arbiter (parameter NREQ): inputs req and pointer; outputs one-hot grant, grant index and any_req. Purely combinational; the pointer register is held in the parent.
- The parent holds the FSM, gap counter, muxes and result pipeline.

Test Plan:
- Reset check: reset=0 for 3 cycles with req=4'b1111 -> grant=0, dp_ce=0, dp_reset=1, res_valid=0. dp_reset=0 one edge after release.
- Single request: req[2] with hitmap 5'h15, lcmap 5'h0A; datapath model echoes with 5-cycle latency.
  - grant=4'b0100 and dp_ce in cycle c.
  - res_valid in c+6 with res_id=2, res_hitmap=5'h15, res_lcmap=5'h0A.
- Round-robin: req=4'b1111 held constant -> grants 0,1,2,3,0 at cycles c, c+4, c+8, c+12, c+16. Never two dp_ce within 4 cycles.
- Hold: assert hold during GAP with req pending -> no issue while hold=1. The earlier item's res_valid still fires at c+6. Issue occurs in the first cycle after hold drops.
- Reset mid-flight: issue in cycle c, reset=0 at c+3 -> no res_valid at c+6, pointer returns to 0, busy=0.
- Pipelined results: issue in cycles c and c+4 with distinct data -> res_valid at c+6 and c+10 with correct ids and data. No corruption from stage overwrite.

Source files
------------

// File: rtl/gf_hitmap_pkg.sv
// Shared constants, FSM state type and helpers for the hitmap/lcmap scheduler.
// No logic, so there is no latency and no backpressure here.
package gf_hitmap_pkg;

  localparam int HIT_W   = 5;
  localparam int DP_LAT  = 5;
  localparam int MIN_GAP = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_rr_arbiter.sv
// Round-robin pick of the first active request at or after the pointer.
// Purely combinational (zero latency); the caller owns the pointer and any stall.
module gf_rr_arbiter
  import gf_hitmap_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] pointer,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_req
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(pointer) + i) % NREQ]) begin
        found                                  = 1'b1;
        grant[(int'(pointer) + i) % NREQ]      = 1'b1;
        grant_idx                              = ID_W'((int'(pointer) + i) % NREQ);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/hitmap_lcmap_sched.sv
// Time-shares the hitmap/lcmap datapath between requesters, one issue per MIN_GAP cycles.
// Result appears DP_LAT+1 cycles after grant; hold only blocks new issue, results never stall.
module hitmap_lcmap_sched
  import gf_hitmap_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ID_W    = gf_hitmap_pkg::clog2(NREQ),
  parameter int MIN_GAP = gf_hitmap_pkg::MIN_GAP,
  parameter int DP_LAT  = gf_hitmap_pkg::DP_LAT
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NREQ-1:0]                        req,
  input  logic [NREQ*gf_hitmap_pkg::HIT_W-1:0]   req_hitmap,
  input  logic [NREQ*gf_hitmap_pkg::HIT_W-1:0]   req_lcmap,
  input  logic                                   hold,
  output logic [NREQ-1:0]                        grant,
  output logic                                   dp_ce,
  output logic                                   dp_reset,
  output logic [gf_hitmap_pkg::HIT_W-1:0]        dp_hitmap,
  output logic [gf_hitmap_pkg::HIT_W-1:0]        dp_lcmap,
  input  logic [gf_hitmap_pkg::HIT_W-1:0]        dp_hitmap_out,
  input  logic [gf_hitmap_pkg::HIT_W-1:0]        dp_lcmap_out,
  output logic                                   res_valid,
  output logic [ID_W-1:0]                        res_id,
  output logic [gf_hitmap_pkg::HIT_W-1:0]        res_hitmap,
  output logic [gf_hitmap_pkg::HIT_W-1:0]        res_lcmap,
  output logic                                   busy
);

  localparam int GAP_W = clog2(MIN_GAP) + 1;

  sched_state_t    state;
  logic [ID_W-1:0] ptr;
  logic [GAP_W-1:0] gap;
  logic [DP_LAT:0] vld_sr;
  logic [ID_W-1:0] id_sr [DP_LAT+1];

  logic [NREQ-1:0] arb_grant;
  logic [ID_W-1:0] arb_idx;
  logic            any_req;
  logic            issue_now;

  gf_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (req),
    .pointer   (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  // gap is loaded together with dp_ce, so it is nonzero throughout ISSUE and the
  // decision for the next issue is taken in the cycle it reaches zero.
  assign issue_now = any_req && !hold && (gap == '0) && !dp_reset;

  assign busy = (|vld_sr) || (gap != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gap        <= '0;
      vld_sr     <= '0;
      for (int i = 0; i <= DP_LAT; i++) id_sr[i] <= '0;
      grant      <= '0;
      dp_ce      <= 1'b0;
      dp_reset   <= 1'b1;
      dp_hitmap  <= '0;
      dp_lcmap   <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_hitmap <= '0;
      res_lcmap  <= '0;
    end else begin
      dp_reset <= 1'b0;
      grant    <= '0;
      dp_ce    <= 1'b0;

      // Tag pipeline: stage 0 lines up with the dp_ce cycle, stage DP_LAT with
      // the cycle the datapath outputs hold that item.
      vld_sr   <= {vld_sr[DP_LAT-1:0], issue_now};
      id_sr[0] <= arb_idx;
      for (int i = 1; i <= DP_LAT; i++) id_sr[i] <= id_sr[i-1];

      res_valid <= vld_sr[DP_LAT];
      if (vld_sr[DP_LAT]) begin
        res_id     <= id_sr[DP_LAT];
        res_hitmap <= dp_hitmap_out;
        res_lcmap  <= dp_lcmap_out;
      end

      if (issue_now) begin
        state     <= ST_ISSUE;
        grant     <= arb_grant;
        dp_ce     <= 1'b1;
        dp_hitmap <= req_hitmap[int'(arb_idx)*HIT_W +: HIT_W];
        dp_lcmap  <= req_lcmap[int'(arb_idx)*HIT_W +: HIT_W];
        gap       <= GAP_W'(MIN_GAP - 1);
        ptr       <= (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + ID_W'(1);
      end else begin
        if (gap != '0) gap <= gap - GAP_W'(1);
        case (state)
          ST_ISSUE: state <= (gap == '0) ? ST_IDLE : ST_GAP;
          ST_GAP:   if (gap == '0) state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hitmap_lcmap_sched.sv
// Directed bench for hitmap_lcmap_sched with a 5-cycle echo datapath model.
// Expected grants/results are queued by the stimulus and popped by a negedge monitor.
module tb_hitmap_lcmap_sched;
  import gf_hitmap_pkg::*;

  localparam int NREQ = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] req_hitmap, req_lcmap;
  logic        hold;
  logic [3:0]  grant;
  logic        dp_ce, dp_reset;
  logic [4:0]  dp_hitmap, dp_lcmap, dp_hitmap_out, dp_lcmap_out;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [4:0]  res_hitmap, res_lcmap;
  logic        busy;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int last_ce = -1;

  typedef struct {
    int         cyc;
    int         id;
    logic [4:0] hit;
    logic [4:0] lc;
  } exp_t;

  exp_t exp_g[$];
  exp_t exp_r[$];
  exp_t mon_e;

  logic [4:0] dpq_h [5];
  logic [4:0] dpq_l [5];

  hitmap_lcmap_sched #(.NREQ(NREQ)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_hitmap    (req_hitmap),
    .req_lcmap     (req_lcmap),
    .hold          (hold),
    .grant         (grant),
    .dp_ce         (dp_ce),
    .dp_reset      (dp_reset),
    .dp_hitmap     (dp_hitmap),
    .dp_lcmap      (dp_lcmap),
    .dp_hitmap_out (dp_hitmap_out),
    .dp_lcmap_out  (dp_lcmap_out),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_hitmap    (res_hitmap),
    .res_lcmap     (res_lcmap),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Datapath model: value presented with dp_ce in cycle c is on the outputs in c+5.
  always @(posedge clock) begin
    if (dp_reset) begin
      for (int i = 0; i < 5; i++) begin
        dpq_h[i] <= 5'h00;
        dpq_l[i] <= 5'h00;
      end
    end else begin
      dpq_h[0] <= dp_ce ? dp_hitmap : 5'h00;
      dpq_l[0] <= dp_ce ? dp_lcmap  : 5'h00;
      for (int i = 1; i < 5; i++) begin
        dpq_h[i] <= dpq_h[i-1];
        dpq_l[i] <= dpq_l[i-1];
      end
    end
  end

  assign dp_hitmap_out = dpq_h[4];
  assign dp_lcmap_out  = dpq_l[4];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [4:0] h, input logic [4:0] l);
    req_hitmap[i*5 +: 5] = h;
    req_lcmap[i*5 +: 5]  = l;
  endtask

  task automatic push_grant(input int c, input int id, input logic [4:0] h, input logic [4:0] l);
    exp_t e;
    e.cyc = c; e.id = id; e.hit = h; e.lc = l;
    exp_g.push_back(e);
  endtask

  task automatic push_item(input int c, input int id, input logic [4:0] h, input logic [4:0] l);
    exp_t e;
    push_grant(c, id, h, l);
    e.cyc = c + 6; e.id = id; e.hit = h; e.lc = l;
    exp_r.push_back(e);
  endtask

  always @(negedge clock) begin
    if (dp_ce) begin
      if (exp_g.size() == 0) begin
        check("unexpected_issue", int'(dp_ce), 0);
      end else begin
        mon_e = exp_g.pop_front();
        check("issue_cycle", cyc, mon_e.cyc);
        check("grant", int'(grant), 1 << mon_e.id);
        check("dp_hitmap", int'(dp_hitmap), int'(mon_e.hit));
        check("dp_lcmap", int'(dp_lcmap), int'(mon_e.lc));
      end
      if (last_ce >= 0) check("ce_spacing_ok", int'(cyc - last_ce >= MIN_GAP), 1);
      last_ce = cyc;
    end else if (grant != 4'b0000) begin
      check("grant_without_ce", int'(grant), 0);
    end
    if (res_valid) begin
      if (exp_r.size() == 0) begin
        check("unexpected_result", int'(res_valid), 0);
      end else begin
        mon_e = exp_r.pop_front();
        check("result_cycle", cyc, mon_e.cyc);
        check("res_id", int'(res_id), mon_e.id);
        check("res_hitmap", int'(res_hitmap), int'(mon_e.hit));
        check("res_lcmap", int'(res_lcmap), int'(mon_e.lc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, c;
    reset      = 1'b0;
    hold       = 1'b0;
    req        = 4'b1111;
    req_hitmap = '0;
    req_lcmap  = '0;

    // Reset held for three edges with all requests active.
    tick(3);
    check("rst_grant", int'(grant), 0);
    check("rst_dp_ce", int'(dp_ce), 0);
    check("rst_dp_reset", int'(dp_reset), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    req   = 4'b0000;
    tick(1);
    check("dp_reset_release", int'(dp_reset), 0);
    check("idle_dp_ce", int'(dp_ce), 0);

    // Round-robin with all four requesting: ids 0,1,2,3,0 every 4 cycles.
    for (int i = 0; i < 4; i++) set_slice(i, 5'(3*i + 1), 5'(31 - i));
    n   = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_item(n + 1 + 4*k, k % 4, 5'(3*(k % 4) + 1), 5'(31 - (k % 4)));
    tick(17);
    req = 4'b0000;
    tick(12);

    // Single request on requester 2; other slices carry junk.
    for (int i = 0; i < 4; i++) set_slice(i, 5'h1F, 5'h1F);
    set_slice(2, 5'h15, 5'h0A);
    n   = cyc;
    req = 4'b0100;
    push_item(n + 1, 2, 5'h15, 5'h0A);
    tick(1);
    req = 4'b0000;
    tick(10);
    check("busy_after_single", int'(busy), 0);

    // Hold raised during the gap: first result still emerges, next issue waits.
    set_slice(3, 5'h07, 5'h18);
    n   = cyc;
    req = 4'b1000;
    push_item(n + 1, 3, 5'h07, 5'h18);
    tick(1);
    c   = cyc;
    req = 4'b0001;
    set_slice(0, 5'h19, 5'h06);
    hold = 1'b1;
    tick(7);
    check("busy_held_idle", int'(busy), 0);
    tick(1);
    hold = 1'b0;
    push_item(cyc + 1, 0, 5'h19, 5'h06);
    tick(1);
    req = 4'b0000;
    tick(12);

    // Reset three cycles after an issue: the item is dropped, pointer returns to 0.
    set_slice(2, 5'h0C, 5'h13);
    n   = cyc;
    req = 4'b0100;
    push_grant(n + 1, 2, 5'h0C, 5'h13);
    tick(1);
    c   = cyc;
    req = 4'b0000;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_dp_reset", int'(dp_reset), 1);
    check("midrst_res_valid", int'(res_valid), 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("dropped_result_c6", int'(res_valid), 0);
    check("dropped_cycle_is_c6", cyc - c, 6);
    set_slice(1, 5'h11, 5'h0E);
    set_slice(3, 5'h03, 5'h1C);
    req = 4'b1010;
    push_item(cyc + 1, 1, 5'h11, 5'h0E);
    tick(1);
    req = 4'b0000;
    tick(12);

    check("grants_outstanding", exp_g.size(), 0);
    check("results_outstanding", exp_r.size(), 0);
    check("final_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
